// File: rtl/cla_nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial CLA adder.
// The slave side is the adder; the master side is the operand source and result consumer.
interface cla_nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// WIDTH-bit adder that reuses a single 4-bit carry-lookahead slice, one nibble per clock,
// LSB nibble first, with the inter-nibble carry held in a register.
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cla_nibble_serial_adder_if.slave    bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    // Returns {c3,c2,c1,c0,s3..s0}; c[i] is the carry out of bit i, so c2 is the carry into bit 3.
    function automatic logic [7:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic [3:0] s;
        g    = x & y;
        p    = x ^ y;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ {c[2:0], ci};
        return {c, s};
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [7:0]       w_slice;
    logic             w_last;

    assign w_nib_a = r_a[{r_idx, 2'b00} +: 4];
    assign w_nib_b = r_b[{r_idx, 2'b00} +: 4];
    assign w_slice = cla4(w_nib_a, w_nib_b, r_carry);
    assign w_last  = (r_idx == LAST_IDX);

    // Next-state decode of the IDLE/RUN/DONE sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and handshake/status flags, all registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt == ST_RUN);
        end
    end

    // Operand capture and the per-nibble accumulate; DONE leaves every result register untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_sum   <= '0;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_slice[3:0];
                    r_carry                    <= w_slice[7];
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_slice[7];
                        r_ovf  <= w_slice[6] ^ w_slice[7];
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_idx <= r_idx;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and randomized
// traffic at WIDTH=16 and WIDTH=8 against an arithmetic reference model.
module tb_cla_nibble_serial_adder;
    logic clk;
    logic rst_n;

    cla_nibble_serial_adder_if #(.WIDTH(16)) if16 ();
    cla_nibble_serial_adder_if #(.WIDTH(8))  if8  ();

    cla_nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    cla_nibble_serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    // Shared drive variables; sel picks which instance sees in_valid/out_ready and is observed.
    logic        sel;
    logic        drv_valid;
    logic        drv_ready;
    logic [15:0] drv_a;
    logic [15:0] drv_b;
    logic        drv_cin;

    assign if16.in_valid  = drv_valid & ~sel;
    assign if16.out_ready = drv_ready & ~sel;
    assign if16.a         = drv_a;
    assign if16.b         = drv_b;
    assign if16.cin       = drv_cin;
    assign if8.in_valid   = drv_valid & sel;
    assign if8.out_ready  = drv_ready & sel;
    assign if8.a          = drv_a[7:0];
    assign if8.b          = drv_b[7:0];
    assign if8.cin        = drv_cin;

    logic [15:0] obs_sum;
    logic        obs_cout, obs_ovf, obs_in_ready, obs_out_valid, obs_busy;
    assign obs_sum       = sel ? {8'h00, if8.sum} : if16.sum;
    assign obs_cout      = sel ? if8.cout      : if16.cout;
    assign obs_ovf       = sel ? if8.ovf       : if16.ovf;
    assign obs_in_ready  = sel ? if8.in_ready  : if16.in_ready;
    assign obs_out_valid = sel ? if8.out_valid : if16.out_valid;
    assign obs_busy      = sel ? if8.busy      : if16.busy;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition, result width w; returns {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input int w);
        int unsigned t;
        int unsigned mask;
        logic [15:0] s;
        logic        co, ov, sa, sb, ss;
        mask = (32'd1 << w) - 32'd1;
        t    = (32'(a) & mask) + (32'(b) & mask) + 32'(cin);
        s    = 16'(t & mask);
        co   = t[w];
        sa   = a[w-1];
        sb   = b[w-1];
        ss   = s[w-1];
        ov   = (sa == sb) && (ss != sa);
        return {ov, co, s};
    endfunction

    task automatic wait_out_valid(input int nib);
        int lat;
        lat = 0;
        while (!obs_out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(nib));
    endtask

    // One full transaction; operands are scrambled right after acceptance.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input logic early, input int stall, input int nib);
        int n;
        n = 0;
        while (!obs_in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 32'(obs_in_ready), 32'd1);
        drv_a     = a;
        drv_b     = b;
        drv_cin   = cin;
        drv_valid = 1'b1;
        drv_ready = early;
        tick();
        drv_valid = 1'b0;
        drv_a     = 16'($urandom);
        drv_b     = 16'($urandom);
        drv_cin   = 1'($urandom);
        chk("busy_run", 32'(obs_busy), 32'd1);
        wait_out_valid(nib);
        chk("sum", 32'(obs_sum), 32'(es));
        chk("cout", 32'(obs_cout), 32'(ec));
        chk("ovf", 32'(obs_ovf), 32'(eo));
        if (!early) begin
            for (int k = 0; k < stall; k++) begin
                tick();
                chk("stall_valid", 32'(obs_out_valid), 32'd1);
                chk("stall_sum", 32'(obs_sum), 32'(es));
            end
        end
        drv_ready = 1'b1;
        tick();
        drv_ready = 1'b0;
        chk("valid_drop", 32'(obs_out_valid), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [17:0] m;
        logic [15:0] ra, rb;
        logic        rc;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        sel = 1'b0; drv_valid = 1'b0; drv_ready = 1'b0;
        drv_a = 16'h0000; drv_b = 16'h0000; drv_cin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_in_ready", 32'(obs_in_ready), 32'd1);
            chk("rst_out_valid", 32'(obs_out_valid), 32'd0);
            chk("rst_busy", 32'(obs_busy), 32'd0);
            chk("rst_sum", 32'(obs_sum), 32'd0);
            chk("rst_cout", 32'(obs_cout), 32'd0);
            chk("rst_ovf", 32'(obs_ovf), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov,
                  1'b0, i, 4);
        end

        // Reset two nibbles into 0xFFFF+0xFFFF: partial sum and earlier cout must vanish.
        drv_a = 16'hFFFF; drv_b = 16'hFFFF; drv_cin = 1'b0; drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(obs_in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(obs_out_valid), 32'd0);
        chk("mid_rst_busy", 32'(obs_busy), 32'd0);
        chk("mid_rst_sum", 32'(obs_sum), 32'd0);
        chk("mid_rst_cout", 32'(obs_cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1, 4);

        // Backpressure: result held while new operands wait on in_valid.
        drv_a = 16'h1234; drv_b = 16'h4321; drv_cin = 1'b1; drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0;
        drv_a = 16'hAAAA; drv_b = 16'hAAAA; drv_cin = 1'b0;
        wait_out_valid(4);
        chk("bp_sum", 32'(obs_sum), 32'h5556);
        drv_a = 16'h1111; drv_b = 16'h2222; drv_cin = 1'b0; drv_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("bp_hold_sum", 32'(obs_sum), 32'h5556);
            chk("bp_hold_valid", 32'(obs_out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(obs_in_ready), 32'd0);
        end
        drv_ready = 1'b1;
        tick();
        drv_ready = 1'b0;
        chk("bp_release_valid", 32'(obs_out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(obs_in_ready), 32'd1);
        chk("bp_release_sum", 32'(obs_sum), 32'h5556);
        tick();
        drv_valid = 1'b0;
        chk("bp_next_busy", 32'(obs_busy), 32'd1);
        wait_out_valid(4);
        chk("bp_next_sum", 32'(obs_sum), 32'h3333);
        drv_ready = 1'b1;
        tick();
        drv_ready = 1'b0;

        // Randomized traffic at both widths.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            tick();
            for (int i = 0; i < 1000; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                if (sel) begin
                    ra = {8'h00, ra[7:0]};
                    rb = {8'h00, rb[7:0]};
                end
                m = model(ra, rb, rc, sel ? 8 : 16);
                do_op(ra, rb, rc, m[15:0], m[16], m[17],
                      ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), sel ? 2 : 4);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
